// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef enum logic [1:0] {
      SCAN       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } kp_state_t;

   // Hex value printed on the key at (row_idx, col_idx).
   function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
      logic [3:0] code;
      case ({row_idx, col_idx})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         4'b11_11: code = 4'hD;
         default:  code = 4'h0;
      endcase
      return code;
   endfunction

   // Index of the lowest-numbered active-low row; only meaningful when some row is low.
   function automatic logic [1:0] first_low_row(input logic [3:0] rows_lvl);
      logic [1:0] idx;
      if (rows_lvl[0] == 1'b0) begin
         idx = 2'd0;
      end else if (rows_lvl[1] == 1'b0) begin
         idx = 2'd1;
      end else if (rows_lvl[2] == 1'b0) begin
         idx = 2'd2;
      end else begin
         idx = 2'd3;
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to a chosen idle level.
module sync_2ff #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // Two back-to-back flops resolve metastability before the level is used.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= RESET_VAL;
         sync_r <= RESET_VAL;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces press and
// release on the latched row, and reports each accepted key exactly once.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 24000,
   parameter int DEBOUNCE_CYCLES = 480000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_DIV) + 1;
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

   localparam logic [DW-1:0] DWELL_ZERO = {DW{1'b0}};
   localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DWELL_MAX  = {DW{1'b1}};
   localparam logic [CW-1:0] DB_ZERO    = {CW{1'b0}};
   localparam logic [CW-1:0] DB_ONE     = CW'(1);
   localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DB_MAX     = {CW{1'b1}};

   logic [NUM_ROWS-1:0] rs_s;

   kp_state_t           state_r,     state_s;
   logic [1:0]          col_idx_r,   col_idx_s;
   logic [1:0]          row_idx_r,   row_idx_s;
   logic [DW-1:0]       dwell_r,     dwell_s;
   logic [CW-1:0]       db_cnt_r,    db_cnt_s;
   logic [NUM_COLS-1:0] cols_r,      cols_s;
   logic [3:0]          key_code_r,  key_code_s;
   logic                key_valid_r, key_valid_s;
   logic                key_held_r,  key_held_s;
   logic                row_low_s;

   sync_2ff #(
      .WIDTH     (NUM_ROWS),
      .RESET_VAL ({NUM_ROWS{1'b1}})
   ) u_row_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rows),
      .q     (rs_s)
   );

   // Level of the latched row only; other rows are ignored once a key is latched.
   assign row_low_s = (rs_s[row_idx_r] == 1'b0);

   // Next-state, counters and output decisions for the scan/debounce FSM.
   always_comb begin
      state_s     = state_r;
      col_idx_s   = col_idx_r;
      row_idx_s   = row_idx_r;
      dwell_s     = dwell_r;
      db_cnt_s    = db_cnt_r;
      key_code_s  = key_code_r;
      key_valid_s = 1'b0;
      key_held_s  = key_held_r;

      case (state_r)
         SCAN: begin
            if (dwell_r >= DWELL_LAST) begin
               dwell_s = DWELL_ZERO;
               if (rs_s != 4'b1111) begin
                  // The sample cycle itself is the first counted low cycle.
                  row_idx_s = first_low_row(rs_s);
                  db_cnt_s  = DB_ONE;
                  state_s   = PRESS_DB;
               end else begin
                  col_idx_s = col_idx_r + 2'd1;
                  db_cnt_s  = DB_ZERO;
               end
            end else begin
               dwell_s = (dwell_r == DWELL_MAX) ? dwell_r : (dwell_r + DWELL_ONE);
            end
         end

         PRESS_DB: begin
            if (row_low_s) begin
               if (db_cnt_r >= DB_LAST) begin
                  key_code_s  = keymap(row_idx_r, col_idx_r);
                  key_valid_s = 1'b1;
                  key_held_s  = 1'b1;
                  db_cnt_s    = DB_ZERO;
                  state_s     = HELD;
               end else begin
                  db_cnt_s = (db_cnt_r == DB_MAX) ? db_cnt_r : (db_cnt_r + DB_ONE);
               end
            end else begin
               // Bounce: abandon this key and move on to the next column.
               col_idx_s = col_idx_r + 2'd1;
               dwell_s   = DWELL_ZERO;
               db_cnt_s  = DB_ZERO;
               state_s   = SCAN;
            end
         end

         HELD: begin
            if (!row_low_s) begin
               // The first high cycle counts toward the release debounce.
               db_cnt_s = DB_ONE;
               state_s  = RELEASE_DB;
            end else begin
               db_cnt_s = DB_ZERO;
            end
         end

         RELEASE_DB: begin
            if (!row_low_s) begin
               if (db_cnt_r >= DB_LAST) begin
                  key_held_s = 1'b0;
                  col_idx_s  = col_idx_r + 2'd1;
                  dwell_s    = DWELL_ZERO;
                  db_cnt_s   = DB_ZERO;
                  state_s    = SCAN;
               end else begin
                  db_cnt_s = (db_cnt_r == DB_MAX) ? db_cnt_r : (db_cnt_r + DB_ONE);
               end
            end else begin
               db_cnt_s = DB_ZERO;
               state_s  = HELD;
            end
         end

         default: begin
            col_idx_s  = 2'd0;
            dwell_s    = DWELL_ZERO;
            db_cnt_s   = DB_ZERO;
            key_held_s = 1'b0;
            state_s    = SCAN;
         end
      endcase
   end

   // Column drive follows the next column index so cols and col_idx change together.
   assign cols_s = ~(4'b0001 << col_idx_s);

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= SCAN;
         col_idx_r   <= 2'd0;
         row_idx_r   <= 2'd0;
         dwell_r     <= DWELL_ZERO;
         db_cnt_r    <= DB_ZERO;
         cols_r      <= 4'b1110;
         key_code_r  <= 4'h0;
         key_valid_r <= 1'b0;
         key_held_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         col_idx_r   <= col_idx_s;
         row_idx_r   <= row_idx_s;
         dwell_r     <= dwell_s;
         db_cnt_r    <= db_cnt_s;
         cols_r      <= cols_s;
         key_code_r  <= key_code_s;
         key_valid_r <= key_valid_s;
         key_held_r  <= key_held_s;
      end
   end

   assign cols      = cols_r;
   assign key_code  = key_code_r;
   assign key_valid = key_valid_r;
   assign key_held  = key_held_r;

endmodule
